cache_mem_responder: RTL and testbench
======================================

Name: cache_mem_responder

Overview:
- Memory-side responder for the cache-control protocol. Serves instruction fetches from the icache (iREN/iaddr → iwait/iload) and data loads/stores from the dcache (dREN/dWEN/daddr/dstore → dwait/dload).
- Arbitrates between the two caches, latches the granted request, and runs a ready-handshake transaction on a single-port RAM.
- Returns exactly one not-wait cycle per completed request.

Parameters:
- TIMEOUT, 64, max cycles to wait for ram_ready before aborting a transaction (≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data word width

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- iREN  in  1  icache read request, held until a not-iwait cycle
- iaddr  in  ADDR_W  icache word address
- iwait  out  1  0 for exactly one cycle when iload is valid
- iload  out  DATA_W  fetched instruction word
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache address
- dstore  in  DATA_W  dcache write data
- dwait  out  1  0 for exactly one cycle when the data access completes
- dload  out  DATA_W  loaded data word
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_store  out  DATA_W  RAM write data
- ram_load  in  DATA_W  RAM read data, valid when ram_ready=1
- ram_ready  in  1  RAM completes current access this cycle
- err  out  1  one-cycle pulse when a transaction hits TIMEOUT

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. RST=1 at an edge forces:
  - state=IDLE
  - iwait=1, dwait=1
  - iload=0, dload=0
  - ram_ren=0, ram_wen=0, ram_addr=0, ram_store=0
  - err=0, timeout counter=0
- Reset mid-transaction drops the RAM access immediately. No response is issued.
- FSM states: IDLE, IFETCH, DLOAD, DSTORE, IRESP, DRESP.
- IDLE: waits stay 1 and RAM strobes stay 0. Grant priority is dWEN > dREN > iREN.
  - On grant, latch address (and dstore for a write) into internal registers.
  - Transition to DSTORE, DLOAD or IFETCH, and clear the counter.
- If dWEN and dREN are both asserted, it is treated as a write. dREN is then serviced after the response cycle if it is still held.
- Service states (IFETCH, DLOAD, DSTORE):
  - Drive ram_addr and ram_store from the latched registers.
  - Assert ram_ren (IFETCH/DLOAD) or ram_wen (DSTORE) every cycle until ram_ready.
  - The counter increments each cycle.
- ram_ready=1 in a service state:
  - Deassert the strobes the next cycle.
  - For a read, register ram_load into iload or dload.
  - Go to IRESP (from IFETCH) or DRESP (from DLOAD/DSTORE).
  - Minimum latency is grant edge → 1 RAM cycle → response cycle, i.e. iwait=0 no earlier than the 2nd cycle after the request was first seen in IDLE.
- IRESP/DRESP: the corresponding wait=0 for exactly one cycle with load data valid, then return to IDLE. The other requester's wait stays 1.
- dload for a store holds its previous value and is don't-care to the cache.
- iload/dload hold their value outside response cycles. The caches must sample only when wait=0.
- Abort: if the granted requester's REN/WEN is low at the ram_ready cycle:
  - The RAM access still completes.
  - The response state is skipped (wait stays 1) and the FSM returns to IDLE.
- Timeout: if the counter reaches TIMEOUT-1 without ram_ready:
  - Strobes drop and err pulses for 1 cycle.
  - The FSM goes to the response state with load data 0, so the requester is never hung.
- Fairness: after a DRESP, if iREN has been pending through the last 2 consecutive data grants, the next IDLE grant goes to iREN regardless of data requests. This is a 2-bit starvation counter, cleared on any instruction grant.
- ram_ren and ram_wen are never both 1. Strobes are never asserted in IDLE or a response state.

Test Plan:
- Single fetch: iREN=1, iaddr=0x40, ram_ready returned 3 cycles after ram_ren rises with ram_load=0x2402000A → ram_addr=0x40, one cycle iwait=0 with iload=0x2402000A, then IDLE; dwait stays 1 throughout.
- Priority: iREN and dREN rise in the same cycle, daddr=0x100, ram_ready immediate → data served first (dwait=0, dload=RAM value), then iaddr fetched; iwait=0 occurs strictly after the dwait pulse.
- Store: dWEN=1, daddr=0x80, dstore=0xDEADBEEF → ram_wen=1, ram_store=0xDEADBEEF, ram_ren=0 throughout; one dwait=0 cycle after ram_ready.
- Starvation: dREN held continuously with iREN high, ram_ready always 1 → instruction granted after at most 2 data responses; iwait=0 observed.
- Timeout: TIMEOUT=8, iREN=1, ram_ready never asserted → ram_ren high 7 cycles, err pulses 1 cycle, iwait=0 once with iload=0.
- Reset mid-op: RST=1 while in DLOAD → next cycle all outputs at reset values, state IDLE, no dwait=0 pulse; a new fetch afterwards completes normally.

Source files
------------

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the icache/dcache control protocol.
// Arbitrates between instruction fetches and data loads/stores, latches the
// granted request and runs one ready-handshake access on a single-port RAM.
// Each completed request gets exactly one not-wait cycle. A stuck RAM is
// cut off after TIMEOUT cycles so that no requester can hang.
module cache_mem_responder #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  // icache side
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  // dcache side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  // RAM side
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              err
);

  // Counter never needs to hold more than TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    StIdle,
    StIfetch,
    StDload,
    StDstore,
    StIresp,
    StDresp
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_d;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_store;
  logic [DATA_W-1:0] r_iload;
  logic [DATA_W-1:0] r_dload;
  logic [1:0]        r_starve;
  logic              r_err;

  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_grant_wr;
  logic              w_live;
  logic              w_complete;
  logic              w_timeout;

  assign ram_addr  = r_addr;
  assign ram_store = r_store;
  assign iload     = r_iload;
  assign dload     = r_dload;
  assign err       = r_err;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state, grant decode, RAM strobes and wait outputs.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_grant_i  = 1'b0;
    w_grant_d  = 1'b0;
    w_grant_wr = 1'b0;
    w_live     = 1'b0;
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        // A starved instruction fetch beats every data request.
        if (r_starve[1] && iREN) begin
          w_grant_i = 1'b1;
          w_state_d = StIfetch;
        end else if (dWEN) begin
          w_grant_d  = 1'b1;
          w_grant_wr = 1'b1;
          w_state_d  = StDstore;
        end else if (dREN) begin
          w_grant_d = 1'b1;
          w_state_d = StDload;
        end else if (iREN) begin
          w_grant_i = 1'b1;
          w_state_d = StIfetch;
        end
      end

      StIfetch, StDload, StDstore: begin
        ram_ren = (r_state != StDstore);
        ram_wen = (r_state == StDstore);
        w_cnt_d = r_cnt + CntW'(1);
        case (r_state)
          StIfetch: w_live = iREN;
          StDload:  w_live = dREN;
          default:  w_live = dWEN;
        endcase
        if (ram_ready) begin
          // Requester gone: let the access finish but skip the response.
          if (w_live) begin
            w_complete = 1'b1;
            w_state_d  = (r_state == StIfetch) ? StIresp : StDresp;
          end else begin
            w_state_d = StIdle;
          end
        end else if (r_cnt == CntLast) begin
          w_timeout = 1'b1;
          w_state_d = (r_state == StIfetch) ? StIresp : StDresp;
        end
      end

      StIresp: begin
        iwait     = 1'b0;
        w_state_d = StIdle;
      end

      StDresp: begin
        dwait     = 1'b0;
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Cycle counter for the timeout and the one-cycle error pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_err <= w_timeout;
    end
  end

  // Latch the granted address and store data for the whole access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr  <= '0;
      r_store <= '0;
    end else begin
      if (w_grant_i) begin
        r_addr <= iaddr;
      end else if (w_grant_d) begin
        r_addr <= daddr;
      end
      if (w_grant_wr) begin
        r_store <= dstore;
      end
    end
  end

  // Capture read data on completion; a timed-out read returns zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_iload <= '0;
      r_dload <= '0;
    end else if (w_complete) begin
      if (r_state == StIfetch) begin
        r_iload <= ram_load;
      end else if (r_state == StDload) begin
        r_dload <= ram_load;
      end
    end else if (w_timeout) begin
      if (r_state == StIfetch) begin
        r_iload <= '0;
      end else if (r_state == StDload) begin
        r_dload <= '0;
      end
    end
  end

  // Starvation counter: data grants that passed over a pending fetch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_starve <= 2'd0;
    end else if (w_grant_i) begin
      r_starve <= 2'd0;
    end else if (w_grant_d) begin
      if (iREN) begin
        r_starve <= (r_starve == 2'd3) ? 2'd3 : r_starve + 2'd1;
      end else begin
        r_starve <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: a RAM model and both cache
// agents are stepped from one process on the falling clock edge.
module tb_cache_mem_responder;

  localparam int unsigned TO = 8;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic        err;

  cache_mem_responder #(
    .TIMEOUT(TO),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ram_ren  (ram_ren),
    .ram_wen  (ram_wen),
    .ram_addr (ram_addr),
    .ram_store(ram_store),
    .ram_load (ram_load),
    .ram_ready(ram_ready),
    .err      (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        is_i;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem[bit [31:0]];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ram_lat = 0;
  bit ram_mute = 0;
  int strobe_cnt = 0;
  int ren_cycles = 0;
  int wen_cycles = 0;
  int err_pulses = 0;
  int i_resp = 0;
  int d_resp = 0;
  int i_resp_cyc = 0;
  int d_resp_cyc = 0;
  int d_at_i = 0;
  bit d_hold = 0;
  logic [31:0] last_addr;
  logic [31:0] last_store;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic push_exp(input logic is_i, input logic chk, input logic [31:0] d);
    exp_t e;
    e.is_i = is_i;
    e.chk  = chk;
    e.data = d;
    sb.push_back(e);
  endtask

  // One clock: RAM model, response scoreboard and cache-side request drops.
  task automatic tick();
    exp_t e;
    @(negedge CLK);
    cyc++;
    if (ram_ren || ram_wen) begin
      if (ram_ren) ren_cycles++;
      if (ram_wen) wen_cycles++;
      last_addr  = ram_addr;
      last_store = ram_store;
      n_vec++;
      if (ram_ren && ram_wen) begin
        n_err++;
        $display("FAIL strobe_excl: ren=%b wen=%b, need at most one", ram_ren, ram_wen);
      end
      if (!ram_mute && strobe_cnt == ram_lat) begin
        ram_ready = 1'b1;
        if (ram_wen) mem[ram_addr] = ram_store;
        ram_load = ram_ren ? mem_rd(ram_addr) : 32'h0BADF00D;
      end else begin
        ram_ready = 1'b0;
        ram_load  = 32'h0BADF00D;
      end
      strobe_cnt++;
    end else begin
      strobe_cnt = 0;
      ram_ready  = 1'b0;
      ram_load   = 32'h0BADF00D;
    end
    if (err) err_pulses++;
    if (!iwait) begin
      i_resp++;
      i_resp_cyc = cyc;
      d_at_i = d_resp;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL i_resp: unexpected iwait=0 iload=%h, no response expected", iload);
      end else begin
        e = sb.pop_front();
        if (!e.is_i || iload !== e.data) begin
          n_err++;
          $display("FAIL i_resp: instr resp iload=%h, expected %s resp data=%h",
                   iload, e.is_i ? "instr" : "data", e.data);
        end
      end
      if (!dwait || ram_ren || ram_wen) begin
        n_err++;
        $display("FAIL i_resp_excl: dwait=%b ren=%b wen=%b, need 1/0/0", dwait, ram_ren, ram_wen);
      end
      iREN = 1'b0;
    end
    if (!dwait) begin
      d_resp++;
      d_resp_cyc = cyc;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL d_resp: unexpected dwait=0 dload=%h, no response expected", dload);
      end else begin
        e = sb.pop_front();
        if (e.is_i || (e.chk && dload !== e.data)) begin
          n_err++;
          $display("FAIL d_resp: data resp dload=%h, expected %s resp data=%h",
                   dload, e.is_i ? "instr" : "data", e.data);
        end
      end
      if (ram_ren || ram_wen) begin
        n_err++;
        $display("FAIL d_resp_strobe: ren=%b wen=%b during response, need 0/0", ram_ren, ram_wen);
      end
      if (dWEN) dWEN = 1'b0;
      else if (!d_hold) dREN = 1'b0;
    end
  endtask

  task automatic drain(input int max, input string name);
    int k = 0;
    while (sb.size() != 0 && k < max) begin
      tick();
      k++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d responses still outstanding after %0d cycles, need 0",
               name, sb.size(), max);
      sb.delete();
    end
  endtask

  task automatic check_reset_vals(input string name);
    logic [132:0] obs;
    logic [132:0] expv;
    obs  = {iwait, dwait, iload, dload, ram_ren, ram_wen, ram_addr, ram_store, err};
    expv = {1'b1, 1'b1, 131'd0};
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: outputs %h, need %h", name, obs, expv);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    check_reset_vals("reset_state");
    RST = 1'b0;
    tick();
    check_reset_vals("idle_after_reset");
  endtask

  task automatic test_single_fetch();
    int t0;
    int rb;
    int db;
    rb = ren_cycles;
    db = d_resp;
    mem[32'h40] = 32'h2402000A;
    ram_lat = 3;
    iREN = 1'b1;
    iaddr = 32'h40;
    t0 = cyc;
    push_exp(1'b1, 1'b1, 32'h2402000A);
    drain(30, "fetch_done");
    n_vec++;
    if (i_resp_cyc - t0 != 5) begin
      n_err++;
      $display("FAIL fetch_latency: %0d cycles, need 5", i_resp_cyc - t0);
    end
    n_vec++;
    if (ren_cycles - rb != 4 || last_addr !== 32'h40) begin
      n_err++;
      $display("FAIL fetch_ram: ren cycles %0d addr %h, need 4 and 00000040",
               ren_cycles - rb, last_addr);
    end
    tick();
    tick();
    n_vec++;
    if (iload !== 32'h2402000A || d_resp != db) begin
      n_err++;
      $display("FAIL fetch_hold: iload %h dresp %0d, need 2402000a and 0", iload, d_resp - db);
    end
  endtask

  task automatic test_priority();
    ram_lat = 0;
    iREN = 1'b1;
    iaddr = 32'h200;
    dREN = 1'b1;
    daddr = 32'h100;
    push_exp(1'b0, 1'b1, mem_rd(32'h100));
    push_exp(1'b1, 1'b1, mem_rd(32'h200));
    drain(40, "priority_done");
    n_vec++;
    if (!(i_resp_cyc > d_resp_cyc)) begin
      n_err++;
      $display("FAIL priority_order: iresp cycle %0d dresp cycle %0d, need iresp later",
               i_resp_cyc, d_resp_cyc);
    end
  endtask

  task automatic test_store();
    int rb;
    int wb;
    rb = ren_cycles;
    wb = wen_cycles;
    ram_lat = 2;
    dWEN = 1'b1;
    daddr = 32'h80;
    dstore = 32'hDEADBEEF;
    push_exp(1'b0, 1'b0, 32'h0);
    drain(20, "store_done");
    n_vec++;
    if (wen_cycles - wb != 3 || ren_cycles != rb || last_addr !== 32'h80 ||
        last_store !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL store_ram: wen %0d ren %0d addr %h data %h, need 3 0 00000080 deadbeef",
               wen_cycles - wb, ren_cycles - rb, last_addr, last_store);
    end
    // Read back what was stored.
    dREN = 1'b1;
    daddr = 32'h80;
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    drain(20, "store_readback");
    // Write and read together: write first, read still held afterwards.
    ram_lat = 1;
    dWEN = 1'b1;
    dREN = 1'b1;
    daddr = 32'h90;
    dstore = 32'h11112222;
    push_exp(1'b0, 1'b0, 32'h0);
    push_exp(1'b0, 1'b1, 32'h11112222);
    drain(30, "write_then_read");
  endtask

  task automatic test_starvation();
    int db;
    int k;
    db = d_resp;
    ram_lat = 0;
    d_hold = 1'b1;
    dREN = 1'b1;
    daddr = 32'h300;
    iREN = 1'b1;
    iaddr = 32'h44;
    push_exp(1'b0, 1'b1, mem_rd(32'h300));
    push_exp(1'b0, 1'b1, mem_rd(32'h300));
    push_exp(1'b1, 1'b1, mem_rd(32'h44));
    push_exp(1'b0, 1'b1, mem_rd(32'h300));
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      tick();
      if (!iREN) d_hold = 1'b0;
      k++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL starve_done: %0d responses outstanding, need 0", sb.size());
      sb.delete();
    end
    d_hold = 1'b0;
    dREN = 1'b0;
    n_vec++;
    if (d_at_i - db != 2) begin
      n_err++;
      $display("FAIL starve_grant: %0d data responses before fetch, need 2", d_at_i - db);
    end
  endtask

  task automatic test_timeout();
    int rb;
    int eb;
    rb = ren_cycles;
    eb = err_pulses;
    ram_mute = 1'b1;
    iREN = 1'b1;
    iaddr = 32'h48;
    push_exp(1'b1, 1'b1, 32'h0);
    drain(30, "timeout_done");
    tick();
    tick();
    ram_mute = 1'b0;
    n_vec++;
    if (ren_cycles - rb != int'(TO) - 1 || err_pulses - eb != 1) begin
      n_err++;
      $display("FAIL timeout: ren cycles %0d err pulses %0d, need %0d and 1",
               ren_cycles - rb, err_pulses - eb, TO - 1);
    end
  endtask

  task automatic test_abort();
    int rb;
    int ib;
    rb = ren_cycles;
    ib = i_resp;
    ram_lat = 3;
    iREN = 1'b1;
    iaddr = 32'h50;
    tick();
    tick();
    iREN = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    n_vec++;
    if (ren_cycles - rb != 4 || i_resp != ib) begin
      n_err++;
      $display("FAIL abort: ren cycles %0d iresp %0d, need 4 and 0", ren_cycles - rb, i_resp - ib);
    end
  endtask

  task automatic test_reset_midop();
    int db;
    db = d_resp;
    ram_lat = 5;
    dREN = 1'b1;
    daddr = 32'h140;
    tick();
    tick();
    n_vec++;
    if (ram_ren !== 1'b1) begin
      n_err++;
      $display("FAIL midop_active: ram_ren %b, need 1", ram_ren);
    end
    RST = 1'b1;
    tick();
    check_reset_vals("midop_reset");
    RST = 1'b0;
    dREN = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    n_vec++;
    if (d_resp != db) begin
      n_err++;
      $display("FAIL midop_noresp: %0d data responses, need 0", d_resp - db);
    end
    ram_lat = 1;
    iREN = 1'b1;
    iaddr = 32'h60;
    push_exp(1'b1, 1'b1, mem_rd(32'h60));
    drain(20, "fetch_after_reset");
  endtask

  initial begin
    RST = 1'b1;
    iREN = 1'b0;
    iaddr = '0;
    dREN = 1'b0;
    dWEN = 1'b0;
    daddr = '0;
    dstore = '0;
    ram_load = '0;
    ram_ready = 1'b0;
    last_addr = '0;
    last_store = '0;
    test_reset();
    test_single_fetch();
    test_priority();
    test_store();
    test_starvation();
    test_timeout();
    test_abort();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
